irq_controller: RTL and testbench

Memory-mapped interrupt controller on the shared data bus that collects the active-low interrupt lines of the peripherals (timer `timer_irq` and others) and schedules them onto a single active-low CPU interrupt. It latches falling edges as pending requests, applies a per-source enable mask, and grants the lowest-numbered enabled pending source through a claim/end-of-interrupt handshake. Only one interrupt is in service at a time; there is no nesting.

---
 rtl/irq_controller.sv | 77 +++++++
 tb/tb_irq_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: latches falling edges of active-low request lines and schedules the
// lowest-numbered enabled one onto a single active-low CPU interrupt via claim/EOI.
module irq_controller #(
    parameter logic [31:0] base_address = 32'h40B0,
    parameter int          num_sources  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    inout  wire  [31:0]            data_bus_data,
    input  logic [31:0]            data_bus_addr,
    input  logic [1:0]             data_bus_mode,
    input  logic [num_sources-1:0] irq_in,
    output logic                   cpu_irq
);
    localparam int N = num_sources;
    typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, SERVICE = 2'd2} state_t;
    state_t      state_q, state_d;
    logic        ctrl_q, ctrl_d, cpu_irq_q;
    logic [N-1:0] enable_q, enable_d, pending_q, pending_d, irq_prev_q;
    logic [N-1:0] edge_s, deliv, clr_mask, win_mask;
    logic [4:0]  isr_id_q, isr_id_d, winner;
    logic [31:0] offset, rdata, claim_data;
    logic        rd, wr, claim, eoi_ok, unused;
    assign offset = data_bus_addr - base_address;
    assign rd     = offset < 32'd6 && data_bus_mode == 2'b01;
    assign wr     = offset < 32'd6 && data_bus_mode == 2'b10;
    assign edge_s = irq_prev_q & ~irq_in;
    assign deliv  = ctrl_q ? (pending_q & enable_q) : '0;
    assign unused = ^data_bus_data[31:N];
    // Descending scan so the lowest set index is the last one to win.
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--)
            if (deliv[i]) winner = 5'(i);
    end
    assign win_mask   = N'(1) << winner;
    assign claim_data = (state_q == REQUEST && deliv != '0) ? {1'b1, 26'b0, winner} : '0;
    assign claim      = rd && offset == 32'd3 && claim_data[31];
    assign eoi_ok     = wr && offset == 32'd4 && state_q == SERVICE && data_bus_data[4:0] == isr_id_q;
    assign clr_mask   = (wr && offset == 32'd2) ? data_bus_data[N-1:0] : '0;
    assign rdata = offset == 32'd0 ? {31'b0, ctrl_q} :
                   offset == 32'd1 ? 32'(enable_q) :
                   offset == 32'd2 ? 32'(pending_q) :
                   offset == 32'd3 ? claim_data :
                   offset == 32'd5 ? {22'b0, state_q, 3'b0, isr_id_q} : '0;
    assign data_bus_data = rd ? rdata : 'z;
    always_comb begin
        ctrl_d    = (wr && offset == 32'd0) ? data_bus_data[0] : ctrl_q;
        enable_d  = (wr && offset == 32'd1) ? data_bus_data[N-1:0] : enable_q;
        // New edges are ORed in last so they beat both write-1-clear and claim.
        pending_d = (pending_q & ~clr_mask & ~(claim ? win_mask : '0)) | edge_s;
        isr_id_d  = claim ? winner : isr_id_q;
        state_d   = state_q == IDLE    ? (deliv != '0 ? REQUEST : IDLE) :
                    state_q == REQUEST ? (deliv == '0 ? IDLE : claim ? SERVICE : REQUEST) :
                    (eoi_ok ? IDLE : SERVICE);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q     <= 1'b0;
            enable_q   <= '0;
            pending_q  <= '0;
            irq_prev_q <= '1;
            isr_id_q   <= '0;
            state_q    <= IDLE;
            cpu_irq_q  <= 1'b1;
        end else begin
            ctrl_q     <= ctrl_d;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_in;
            isr_id_q   <= isr_id_d;
            state_q    <= state_d;
            cpu_irq_q  <= state_d != REQUEST;
        end
    end
    assign cpu_irq = cpu_irq_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scoreboard bench for irq_controller.
module tb_irq_controller;
    localparam logic [31:0] BASE = 32'h40B0;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  mode = 2'b00;
    logic        drv = 1'b0;
    logic [7:0]  irq = 8'hFF;
    logic        cpu_irq;
    wire  [31:0] bus;
    int vectors = 0, miscompares = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    assign bus = drv ? wdata : 'z;
    always #5 clk = ~clk;
    irq_controller #(.base_address(BASE), .num_sources(8)) dut (
        .clk(clk), .reset(reset), .data_bus_data(bus), .data_bus_addr(addr),
        .data_bus_mode(mode), .irq_in(irq), .cpu_irq(cpu_irq)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(string t, logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask
    task automatic compare(logic [31:0] obs);
        string t;
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard-empty: observed %h required nothing", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask
    task automatic bus_wr(logic [2:0] off, logic [31:0] v);
        addr = BASE + 32'(off); mode = 2'b10; drv = 1'b1; wdata = v;
        tick();
        mode = 2'b00; drv = 1'b0;
    endtask
    task automatic rd_chk(string t, logic [2:0] off, logic [31:0] v);
        logic [31:0] obs;
        push(t, v);
        addr = BASE + 32'(off); mode = 2'b01;
        #1;
        obs = bus;
        tick();
        mode = 2'b00;
        compare(obs);
    endtask
    task automatic irq_chk(string t, logic v);
        push(t, {31'b0, v});
        compare({31'b0, cpu_irq});
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end
    initial begin
        tick(); tick();
        reset = 1'b1;
        irq_chk("rst_cpu_irq", 1'b1);
        rd_chk("rst_ctrl", 3'd0, 32'h0);
        rd_chk("rst_enable", 3'd1, 32'h0);
        rd_chk("rst_pending", 3'd2, 32'h0);
        rd_chk("rst_status", 3'd5, 32'h0);
        // Timer delivery on source 0
        bus_wr(3'd0, 32'h1);
        bus_wr(3'd1, 32'h01);
        irq[0] = 1'b0; tick(); irq = 8'hFF;
        irq_chk("t0_cpu_before", 1'b1);
        rd_chk("t0_pending", 3'd2, 32'h01);
        irq_chk("t0_cpu_low", 1'b0);
        rd_chk("t0_status_req", 3'd5, 32'h100);
        rd_chk("t0_claim", 3'd3, 32'h8000_0000);
        irq_chk("t0_cpu_after_claim", 1'b1);
        rd_chk("t0_status_svc", 3'd5, 32'h200);
        bus_wr(3'd4, 32'h0);
        rd_chk("t0_status_idle", 3'd5, 32'h0);
        // Priority: sources 5 and 2 together
        bus_wr(3'd1, 32'hFF);
        irq = ~8'b0010_0100; tick(); irq = 8'hFF;
        tick();
        irq_chk("pri_cpu_low", 1'b0);
        rd_chk("pri_claim1", 3'd3, 32'h8000_0002);
        irq_chk("pri_cpu_high", 1'b1);
        bus_wr(3'd4, 32'h2);
        irq_chk("pri_cpu_eoi_edge", 1'b1);
        tick();
        irq_chk("pri_cpu_low2", 1'b0);
        rd_chk("pri_claim2", 3'd3, 32'h8000_0005);
        bus_wr(3'd4, 32'h5);
        irq_chk("pri_cpu_done", 1'b1);
        rd_chk("pri_pending", 3'd2, 32'h0);
        // Masking
        bus_wr(3'd1, 32'h00);
        irq[3] = 1'b0; tick(); irq = 8'hFF;
        tick();
        irq_chk("mask_cpu_high", 1'b1);
        rd_chk("mask_pending", 3'd2, 32'h08);
        bus_wr(3'd1, 32'h08);
        irq_chk("mask_cpu_wr_edge", 1'b1);
        tick();
        irq_chk("mask_cpu_low", 1'b0);
        // Write-1-clear, then clear racing a new edge
        bus_wr(3'd2, 32'h08);
        rd_chk("clr_pending", 3'd2, 32'h0);
        irq_chk("clr_cpu_high", 1'b1);
        irq[3] = 1'b0;
        bus_wr(3'd2, 32'h08);
        irq = 8'hFF;
        rd_chk("setwins_pending", 3'd2, 32'h08);
        rd_chk("eoi_claim", 3'd3, 32'h8000_0003);
        // EOI handshake
        bus_wr(3'd4, 32'h5);
        rd_chk("eoi_wrong_status", 3'd5, 32'h203);
        rd_chk("eoi_reclaim", 3'd3, 32'h0);
        rd_chk("eoi_status_again", 3'd5, 32'h203);
        // Reset mid-service with source 1 held low
        irq[1] = 1'b0;
        reset = 1'b0; tick(); reset = 1'b1;
        irq_chk("mrst_cpu", 1'b1);
        rd_chk("mrst_pending0", 3'd2, 32'h0);
        rd_chk("mrst_status", 3'd5, 32'h0);
        rd_chk("mrst_ctrl", 3'd0, 32'h0);
        rd_chk("mrst_enable", 3'd1, 32'h0);
        rd_chk("mrst_pending1", 3'd2, 32'h02);
        rd_chk("mrst_pending_once", 3'd2, 32'h02);
        irq_chk("mrst_cpu_end", 1'b1);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard-leftover: observed %0d entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
